// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: skid-stage occupancy encoding and the default NOP encoding.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } skid_state_e;

   localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         i_rst,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (i_inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + {{(W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_count = count_q;

endmodule

// File: rtl/if_id_skid_stage.sv
// Two-entry IF/ID skid buffer with flush and halt; o_ready depends on registered state only.
// Optional stall counter output enabled by defining IFID_STALL_CNT_EN.
module if_id_skid_stage
   import pipe_pkg::*;
#(
   parameter int unsigned        INSTR_W   = 32,
   parameter int unsigned        PC_W      = 32,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_DEFAULT),
   parameter int unsigned        CNT_W     = 16
) (
   input  logic               clk,
   input  logic               i_rst,
   input  logic               i_halt,
   input  logic               i_flush,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [INSTR_W-1:0] i_instruction,
   input  logic [PC_W-1:0]    i_pc,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [INSTR_W-1:0] o_instruction,
   output logic [PC_W-1:0]    o_pc
`ifdef IFID_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0]   o_stall_cnt
`endif
);

   if (CNT_W == 0) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
   end

   skid_state_e        state_q, state_d;
   logic [INSTR_W-1:0] main_instr_q, main_instr_d;
   logic [PC_W-1:0]    main_pc_q, main_pc_d;
   logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
   logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
   logic               in_xfer, out_xfer;

   // Halt gates both handshakes, so the next-state logic holds without a dedicated branch.
   assign o_ready  = !i_halt && (state_q != TWO);
   assign o_valid  = !i_halt && (state_q != EMPTY);
   assign in_xfer  = i_valid && o_ready;
   assign out_xfer = o_valid && i_ready;

   assign o_instruction = o_valid ? main_instr_q : NOP_INSTR;
   assign o_pc          = o_valid ? main_pc_q : '0;

   always_comb begin
      state_d      = state_q;
      main_instr_d = main_instr_q;
      main_pc_d    = main_pc_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      if (i_flush) begin
         state_d      = EMPTY;
         main_instr_d = NOP_INSTR;
         main_pc_d    = '0;
         skid_instr_d = NOP_INSTR;
         skid_pc_d    = '0;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_xfer) begin
                  state_d      = ONE;
                  main_instr_d = i_instruction;
                  main_pc_d    = i_pc;
               end
            end
            ONE: begin
               if (in_xfer && !out_xfer) begin
                  state_d      = TWO;
                  skid_instr_d = i_instruction;
                  skid_pc_d    = i_pc;
               end else if (out_xfer && !in_xfer) begin
                  state_d = EMPTY;
               end else if (in_xfer && out_xfer) begin
                  main_instr_d = i_instruction;
                  main_pc_d    = i_pc;
               end
            end
            TWO: begin
               if (out_xfer) begin
                  state_d      = ONE;
                  main_instr_d = skid_instr_q;
                  main_pc_d    = skid_pc_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q      <= EMPTY;
         main_instr_q <= NOP_INSTR;
         main_pc_q    <= '0;
         skid_instr_q <= NOP_INSTR;
         skid_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         main_instr_q <= main_instr_d;
         main_pc_q    <= main_pc_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
      end
   end

`ifdef IFID_STALL_CNT_EN
   logic stall_inc;

   assign stall_inc = (state_q != EMPTY) && !i_ready && !i_halt;

   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk     (clk),
      .i_rst   (i_rst),
      .i_inc   (stall_inc),
      .o_count (o_stall_cnt)
   );
`endif

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed self-checking bench for if_id_skid_stage; stall counter checks when IFID_STALL_CNT_EN.
module tb_if_id_skid_stage;

   logic        clk;
   logic        i_rst;
   logic        i_halt;
   logic        i_flush;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_instruction;
   logic [31:0] i_pc;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_instruction;
   logic [31:0] o_pc;
`ifdef IFID_STALL_CNT_EN
   logic [3:0]  o_stall_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   if_id_skid_stage #(
      .INSTR_W   (32),
      .PC_W      (32),
      .NOP_INSTR (32'h0000_0000),
      .CNT_W     (4)
   ) dut (
      .clk           (clk),
      .i_rst         (i_rst),
      .i_halt        (i_halt),
      .i_flush       (i_flush),
      .i_valid       (i_valid),
      .o_ready       (o_ready),
      .i_instruction (i_instruction),
      .i_pc          (i_pc),
      .o_valid       (o_valid),
      .i_ready       (i_ready),
      .o_instruction (o_instruction),
      .o_pc          (o_pc)
`ifdef IFID_STALL_CNT_EN
      ,
      .o_stall_cnt   (o_stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Apply inputs mid-cycle and let combinational outputs settle.
   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic rdy, input logic halt, input logic flush, input logic rst);
      i_valid       = v;
      i_instruction = instr;
      i_pc          = pc;
      i_ready       = rdy;
      i_halt        = halt;
      i_flush       = flush;
      i_rst         = rst;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, 64'(o_valid), 64'd0);
      check({tag, "_ready"}, 64'(o_ready), 64'd1);
      check({tag, "_instr"}, 64'(o_instruction), 64'd0);
      check({tag, "_pc"}, 64'(o_pc), 64'd0);
   endtask

   initial begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_idle("reset");
`ifdef IFID_STALL_CNT_EN
      check("reset_cnt", 64'(o_stall_cnt), 64'd0);
`endif

      // Streaming: one entry per cycle, one cycle of latency.
      drive(1'b1, 32'h11, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("stream0_ready", 64'(o_ready), 64'd1);
      check("stream0_valid", 64'(o_valid), 64'd0);
      tick();
      drive(1'b1, 32'h22, 32'h4, 1'b1, 1'b0, 1'b0, 1'b0);
      check("stream1_instr", 64'(o_instruction), 64'h11);
      check("stream1_pc", 64'(o_pc), 64'h0);
      check("stream1_ready", 64'(o_ready), 64'd1);
      tick();
      drive(1'b1, 32'h33, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0);
      check("stream2_instr", 64'(o_instruction), 64'h22);
      check("stream2_pc", 64'(o_pc), 64'h4);
      check("stream2_ready", 64'(o_ready), 64'd1);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("stream3_instr", 64'(o_instruction), 64'h33);
      check("stream3_pc", 64'(o_pc), 64'h8);
      check("stream3_valid", 64'(o_valid), 64'd1);
      tick();
      check("stream_drain_valid", 64'(o_valid), 64'd0);

      // Skid: second entry captured while ID stalls.
      drive(1'b1, 32'h11, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h22, 32'h14, 1'b0, 1'b0, 1'b0, 1'b0);
      check("skid_one_ready", 64'(o_ready), 64'd1);
      check("skid_one_instr", 64'(o_instruction), 64'h11);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("skid_two_ready", 64'(o_ready), 64'd0);
      check("skid_two_instr", 64'(o_instruction), 64'h11);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("skid_out0_instr", 64'(o_instruction), 64'h11);
      check("skid_out0_pc", 64'(o_pc), 64'h10);
      check("skid_out0_ready", 64'(o_ready), 64'd0);
      tick();
      check("skid_out1_instr", 64'(o_instruction), 64'h22);
      check("skid_out1_pc", 64'(o_pc), 64'h14);
      check("skid_out1_ready", 64'(o_ready), 64'd1);
      tick();
      check("skid_drain_valid", 64'(o_valid), 64'd0);

      // Flush in TWO with a new entry offered.
      drive(1'b1, 32'h11, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h22, 32'h24, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h33, 32'h28, 1'b0, 1'b0, 1'b1, 1'b0);
      check("flush_pre_ready", 64'(o_ready), 64'd0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_idle("flush");
      for (int i = 0; i < 3; i++) begin
         tick();
         check("flush_no33_valid", 64'(o_valid), 64'd0);
      end

      // Halt in ONE for five cycles.
      drive(1'b1, 32'h44, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'h55, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0);
         check("halt_valid", 64'(o_valid), 64'd0);
         check("halt_ready", 64'(o_ready), 64'd0);
         check("halt_instr", 64'(o_instruction), 64'd0);
         tick();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("halt_after_valid", 64'(o_valid), 64'd1);
      check("halt_after_instr", 64'(o_instruction), 64'h44);
      check("halt_after_pc", 64'(o_pc), 64'h100);
      check("halt_after_ready", 64'(o_ready), 64'd1);

      // Reset while in TWO.
      drive(1'b1, 32'h66, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check("rst_pre_ready", 64'(o_ready), 64'd0);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_idle("rst_two");
      tick();
      check("rst_two_stays_empty", 64'(o_valid), 64'd0);

      // Reset with flush and halt also asserted.
      drive(1'b1, 32'h77, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h88, 32'h404, 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_idle("rst_all");

`ifdef IFID_STALL_CNT_EN
      // Load cycle starts in EMPTY, so counting begins the cycle after.
      drive(1'b1, 32'h99, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check("cnt_start", 64'(o_stall_cnt), 64'd0);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) tick();
      check("cnt_three", 64'(o_stall_cnt), 64'd3);
      for (int i = 0; i < 17; i++) tick();
      check("cnt_sat", 64'(o_stall_cnt), 64'd15);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("cnt_flush_valid", 64'(o_valid), 64'd0);
      check("cnt_after_flush", 64'(o_stall_cnt), 64'd15);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      check("cnt_rst", 64'(o_stall_cnt), 64'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/if_id_skid_stage.md
IF_ID_SKID_STAGE -- requirements
Module: if_id_skid_stage

Interface
REQ-001 SHALL have parameter INSTR_W, default 32, instruction payload width.
REQ-002 SHALL have parameter PC_W, default 32, PC payload width.
REQ-003 SHALL have parameter NOP_INSTR, default 32'h0000_0000, value driven on o_instruction when o_valid=0.
REQ-004 SHALL have parameter CNT_W, default 16, stall-counter width (used only with IFID_STALL_CNT_EN).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-006 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_halt  input  1  freeze all state; no transfers.
REQ-008 SHALL have port i_flush  input  1  discard all held entries (branch/jump redirect).
REQ-009 SHALL have port i_valid  input  1  IF presents an entry.
REQ-010 SHALL have port o_ready  output  1  stage accepts an entry this cycle.
REQ-011 SHALL have port i_instruction  input  INSTR_W  fetched instruction.
REQ-012 SHALL have port i_pc  input  PC_W  PC of fetched instruction.
REQ-013 SHALL have port o_valid  output  1  ID-side entry valid.
REQ-014 SHALL have port i_ready  input  1  ID accepts the entry (deasserted for hazard stall).
REQ-015 SHALL have port o_instruction  output  INSTR_W  head instruction, or NOP_INSTR.
REQ-016 SHALL have port o_pc  output  PC_W  head PC, or 0 when o_valid=0.

Function
REQ-017 SHALL hold two entries, main (head) and skid, tracked by state EMPTY, ONE, TWO.
REQ-018 SHALL define in_xfer = i_valid & o_ready and out_xfer = o_valid & i_ready.
REQ-019 SHALL drive o_ready = !i_halt & (state != TWO), derived from registered state only (no path from i_ready).
REQ-020 SHALL drive o_valid = !i_halt & (state != EMPTY).
REQ-021 SHALL transition EMPTY->ONE on in_xfer, loading main.
REQ-022 SHALL, in ONE: on in_xfer & !out_xfer go to TWO, loading skid; on out_xfer & !in_xfer go to EMPTY; on both stay ONE, loading main from input; on neither hold.
REQ-023 SHALL, in TWO: on out_xfer go to ONE, moving skid into main; otherwise hold.
REQ-024 SHALL give 1-cycle latency: an entry accepted in cycle N is presented with o_valid=1 in cycle N+1.
REQ-025 SHALL preserve order; no entry is dropped or duplicated except by flush.
REQ-026 SHALL, on i_flush (no reset), go to EMPTY next cycle with main/skid cleared to NOP_INSTR/0, dropping any simultaneous in_xfer.
REQ-027 SHALL give priority i_rst > i_flush > i_halt > normal operation.
REQ-028 SHALL, with i_halt=1 and no flush, keep all state and payload unchanged.

Reset
REQ-029 SHALL, on i_rst, go to EMPTY next cycle: o_valid=0, o_ready=1 (if i_halt=0), o_instruction=NOP_INSTR, o_pc=0, counter=0.
REQ-030 SHALL, on reset mid-operation, discard held entries with no partial transfer.

Configuration
REQ-031 SHALL, with IFID_STALL_CNT_EN defined, add output o_stall_cnt[CNT_W] counting cycles with state!=EMPTY & !i_ready & !i_halt, saturating at all-ones, cleared only by i_rst (not by flush).
REQ-032 SHALL, without IFID_STALL_CNT_EN, omit o_stall_cnt and its logic entirely; all other behaviour is identical.

Structure
REQ-033 SHALL place the state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) and the default NOP constant in shared package pipe_pkg.
REQ-034 SHALL implement the optional counter as sub-module sat_counter (parameter W; ports clk, i_rst, i_inc, o_count).

Verification
REQ-035 SHALL verify stream: i_valid=1 and i_ready=1 constantly with instr 0x11,0x22,0x33 -> o_instruction 0x11,0x22,0x33 in consecutive cycles, o_ready always 1.
REQ-036 SHALL verify skid: 0x11 accepted, i_ready=0, 0x22 offered -> state TWO, o_ready=0; i_ready=1 -> 0x11 then 0x22 out, o_ready=1 after 0x11 leaves.
REQ-037 SHALL verify flush in TWO with i_valid=1 (0x33) -> next cycle o_valid=0, o_instruction=0, o_ready=1; 0x33 never appears.
REQ-038 SHALL verify halt in ONE (main=0x44, pc=0x100) for 5 cycles -> o_valid=0, o_ready=0; after halt drops, 0x44/0x100 presented.
REQ-039 SHALL verify reset asserted in TWO -> next cycle EMPTY, outputs at reset values; reset with flush and halt all asserted -> reset values.
REQ-040 SHALL verify, with IFID_STALL_CNT_EN and CNT_W=4, 20 cycles of held entry with i_ready=0 -> o_stall_cnt=15 (saturated); flush leaves it at 15.
